// File: rtl/crc_pkg.sv
// Shared CRC-16/CCITT-FALSE definitions for the frame writer and the frame checker.
// Contains the polynomial/init constants, the writer FSM state type and the byte update.
package crc_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC_HI,
    ST_CRC_LO,
    ST_DONE
  } wr_state_t;

  // MSB-first, unreflected: the byte enters the top of the register, then 8 shifts.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_update.sv
// Combinational next-CRC for one payload byte.
// Wraps crc16_byte so the writer datapath has a single, named update point.
module crc16_update
  import crc_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  assign o_crc = crc16_byte(i_crc, i_data);

endmodule

// File: rtl/crc_frame_writer.sv
// Writes a payload byte stream to consecutive memory addresses, then appends its
// big-endian CRC-16 so the checker can later fetch and verify the frame.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start; base address latched on start
// ST_DATA   | accepting payload beats, one write per accepted beat
// ST_CRC_HI | writing CRC high byte at base+count
// ST_CRC_LO | writing CRC low byte at base+count+1
// ST_DONE   | publishing frame_len/crc_out and pulsing done
module crc_frame_writer
  import crc_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 1022
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   frame_len,
  output logic [15:0]       crc_out
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_LEN - 1);

  wr_state_t         r_state;
  wr_state_t         w_state_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_crc;
  logic [15:0]       w_crc_next;
  logic              w_accept;
  logic              w_at_max;
  logic [ADDR_W-1:0] w_wr_addr;

  logic              r_din_ready;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_frame_len;
  logic [15:0]       r_crc_out;

  crc16_update u_crc16_update (
    .i_crc  (r_crc),
    .i_data (din),
    .o_crc  (w_crc_next)
  );

  assign w_accept  = (r_state == ST_DATA) && din_valid;
  assign w_at_max  = (r_count == LAST_IDX);
  // Offset arithmetic deliberately truncates so frames wrap past the top of memory.
  assign w_wr_addr = r_base + r_count[ADDR_W-1:0];

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_DATA;
      ST_DATA:   if (w_accept && (din_last || w_at_max)) w_state_next = ST_CRC_HI;
      ST_CRC_HI: w_state_next = ST_CRC_LO;
      ST_CRC_LO: w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_base      <= '0;
      r_count     <= '0;
      r_crc       <= '0;
      r_din_ready <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_frame_len <= '0;
      r_crc_out   <= '0;
    end else begin
      r_mem_we    <= 1'b0;
      r_done      <= 1'b0;
      r_din_ready <= (w_state_next == ST_DATA);
      r_busy      <= (w_state_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= base_addr;
            r_crc   <= CRC_INIT;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_wr_addr;
            r_mem_wdata <= din;
            r_crc       <= w_crc_next;
            r_count     <= r_count + 1'b1;
            // Frame cut at capacity: the beat still lands, but the frame is flagged.
            if (w_at_max && !din_last) r_err <= 1'b1;
          end
        end
        ST_CRC_HI: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_wr_addr;
          r_mem_wdata <= r_crc[15:8];
        end
        ST_CRC_LO: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_wr_addr + ADDR_W'(1);
          r_mem_wdata <= r_crc[7:0];
        end
        ST_DONE: begin
          r_done      <= 1'b1;
          r_frame_len <= r_count;
          r_crc_out   <= r_crc;
        end
        default: ;
      endcase
    end
  end

  assign din_ready = r_din_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign frame_len = r_frame_len;
  assign crc_out   = r_crc_out;

endmodule

// File: tb/tb_crc_frame_writer.sv
// Scoreboard bench for crc_frame_writer: expected memory writes are queued as
// stimulus is driven and popped as the DUT strobes mem_we.
module tb_crc_frame_writer;

  localparam int ADDR_W  = 10;
  localparam int MAX_LEN = 1022;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic              clk50m = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        din;
  logic              din_valid;
  logic              din_last;
  logic              din_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   frame_len;
  logic [15:0]       crc_out;

  int   checks   = 0;
  int   failures = 0;
  wr_t  sb[$];
  logic [7:0] payload [0:1023];

  crc_frame_writer #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk50m    (clk50m),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .frame_len (frame_len),
    .crc_out   (crc_out)
  );

  always #5 clk50m = ~clk50m;

  // Bit-serial reference: feedback = msb xor incoming bit.
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ payload[i][b];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Advance one cycle; any write seen mid-cycle is checked against the scoreboard.
  task automatic tick();
    wr_t e;
    @(negedge clk50m);
    if (mem_we !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got we=%b addr=%h data=%h required no write",
                 mem_we, mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (mem_we !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin
          failures++;
          $display("FAIL sb_write got addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
    @(posedge clk50m);
    #1;
  endtask

  task automatic load_check_string();
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
  endtask

  task automatic run_frame(input logic [9:0] base, input int n, input bit use_last,
                           input bit gaps, input logic [15:0] exp_crc, input bit exp_err,
                           input string name);
    int         limit;
    logic [9:0] a;
    wr_t        w;
    limit = (use_last && n <= MAX_LEN) ? n : MAX_LEN;
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    base_addr = '0;
    checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s_start got busy=%b ready=%b err=%b required 1 1 0", name, busy, din_ready, err);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        din_valid = 1'b0;
        din_last  = 1'b0;
        tick();
      end
      din       = payload[i];
      din_valid = 1'b1;
      din_last  = use_last && (i == n - 1);
      checks++;
      if (din_ready !== (i < limit)) begin
        failures++;
        $display("FAIL %s_ready beat=%0d got %b required %b", name, i, din_ready, (i < limit));
      end
      if (i >= limit) break;
      a = base + 10'(i);
      w.addr = a;
      w.data = payload[i];
      sb.push_back(w);
      tick();
    end
    din_valid = (n > limit);
    din_last  = 1'b0;
    a = base + 10'(limit);
    w.addr = a;
    w.data = exp_crc[15:8];
    sb.push_back(w);
    w.addr = a + 10'd1;
    w.data = exp_crc[7:0];
    sb.push_back(w);
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (done !== (j == 4) || busy !== (j != 4)) begin
        failures++;
        $display("FAIL %s_tail L+%0d got done=%b busy=%b required %b %b",
                 name, j, done, busy, (j == 4), (j != 4));
      end
      tick();
    end
    din_valid = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got %b required 0", name, done);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes got %0d pending required 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (crc_out !== exp_crc) begin
      failures++;
      $display("FAIL %s_crc got %h required %h", name, crc_out, exp_crc);
    end
    checks++;
    if (frame_len !== 11'(limit) || err !== exp_err) begin
      failures++;
      $display("FAIL %s_len_err got len=%0d err=%b required len=%0d err=%b",
               name, frame_len, err, limit, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({din_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || frame_len !== '0 || crc_out !== '0) begin
      failures++;
      $display("FAIL reset_values got rdy=%b we=%b busy=%b done=%b err=%b addr=%h wd=%h len=%0d crc=%h required all 0",
               din_ready, mem_we, busy, done, err, mem_addr, mem_wdata, frame_len, crc_out);
    end
    din = 8'hA5;
    din_valid = 1'b1;
    repeat (3) tick();
    din_valid = 1'b0;
    checks++;
    if (din_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_valid got rdy=%b busy=%b required 0 0", din_ready, busy);
    end
  endtask

  task automatic test_check_string();
    load_check_string();
    run_frame(10'h000, 9, 1'b1, 1'b0, 16'h29B1, 1'b0, "check_string");
  endtask

  task automatic test_single_byte();
    payload[0] = 8'h00;
    run_frame(10'h100, 1, 1'b1, 1'b0, 16'hE1F0, 1'b0, "single_byte");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) payload[i] = 8'(i + 1);
    run_frame(10'h3FC, 4, 1'b1, 1'b0, crc_model(4), 1'b0, "wrap");
    run_frame(10'h000, 4, 1'b1, 1'b0, crc_model(4), 1'b0, "wrap_base0");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 1023; i++) payload[i] = 8'($urandom_range(0, 255));
    run_frame(10'h000, 1023, 1'b0, 1'b0, crc_model(MAX_LEN), 1'b1, "overflow");
  endtask

  task automatic test_gaps();
    load_check_string();
    run_frame(10'h080, 9, 1'b1, 1'b1, 16'h29B1, 1'b0, "gaps");
  endtask

  task automatic test_rst_mid_frame();
    wr_t w;
    load_check_string();
    start = 1'b1;
    base_addr = 10'h040;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = payload[i];
      din_valid = 1'b1;
      din_last = 1'b0;
      if (i == 1) begin
        start = 1'b1;
        base_addr = 10'h200;
      end
      w.addr = 10'h040 + 10'(i);
      w.data = payload[i];
      sb.push_back(w);
      tick();
      start = 1'b0;
      base_addr = '0;
    end
    rst = 1'b1;
    din_valid = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if ({din_ready, mem_we, busy, done, err} !== 5'b0 || frame_len !== '0 || crc_out !== '0) begin
      failures++;
      $display("FAIL rst_mid_frame got rdy=%b we=%b busy=%b done=%b err=%b len=%0d crc=%h required all 0",
               din_ready, mem_we, busy, done, err, frame_len, crc_out);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rst_partial_writes got %0d pending required 0", sb.size());
      sb.delete();
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_done got done=%b busy=%b required 0 0", done, busy);
    end
    run_frame(10'h040, 9, 1'b1, 1'b0, 16'h29B1, 1'b0, "after_rst");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    din = '0;
    din_valid = 1'b0;
    din_last = 1'b0;
    @(posedge clk50m);
    #1;
    test_reset();
    test_check_string();
    test_single_byte();
    test_wrap();
    test_overflow();
    test_gaps();
    test_rst_mid_frame();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_frame_writer.md
# crc_frame_writer

Byte-stream-to-memory frame writer with CRC-16 append; the write-side counterpart to the memory-fetching CRC checker. It accepts a payload byte stream over a valid/ready handshake and writes each byte to consecutive memory addresses starting at a latched base address. It then appends the big-endian CRC-16/CCITT-FALSE of the payload, so the checker can later read and verify the frame.

## Interface
Parameters:
- ADDR_W, 10, memory address width (1024-byte memory)
- MAX_LEN, 1022, maximum payload bytes per frame (payload + 2 CRC bytes ≤ 2^ADDR_W)

Ports:
- clk50m  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- base_addr  in  ADDR_W  first write address; latched on accepted start
- din  in  8  payload byte
- din_valid  in  1  din holds a valid byte
- din_last  in  1  qualifies din as the final payload byte
- din_ready  out  1  block accepts din this cycle
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe, one byte per cycle high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when frame and CRC are fully written
- err  out  1  overflow flag for the last frame; held until next start
- frame_len  out  ADDR_W+1  payload byte count of the last frame; held
- crc_out  out  16  CRC of the last frame; held

## Operation
- CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, no reflection, xorout 0x0000. One byte is folded per accepted beat.
- FSM states: IDLE, DATA, CRC_HI, CRC_LO, DONE.
- **IDLE**
  - din_ready=0, busy=0.
  - start=1: latch base_addr, crc←0xFFFF, count←0, err←0, then go to DATA.
- **DATA**
  - din_ready=1. A beat is accepted when din_valid=1 in this state.
  - Each accepted beat writes din at base+count, folds din into crc, and increments count.
  - din_last=1 on an accepted beat: go to CRC_HI.
  - Accepted beat with count=MAX_LEN-1 and din_last=0: treat the beat as last and set err=1. Later input is not accepted.
- **CRC_HI**: write crc[15:8] at base+count.
- **CRC_LO**: write crc[7:0] at base+count+1.
- **DONE**: done=1 for one cycle, frame_len←count, crc_out←crc, then go to IDLE.
- Addresses are base+offset modulo 2^ADDR_W and wrap silently past the top of memory.
- Minimum payload is 1 byte. A zero-length frame is impossible.
- start outside IDLE is ignored.
- din_valid outside DATA is ignored; no handshake occurs.
- rst mid-frame:
  - Next cycle is IDLE with mem_we=0 and all outputs at reset values.
  - Partial writes already issued stay in memory. No done pulse.

## Timing
- All outputs are registered.
- Reset values: din_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, frame_len=0, crc_out=0x0000.
- Cycle S is the edge where start is accepted:
  - busy=1 and din_ready=1 from cycle S+1.
- Write latency: a beat accepted at edge E appears as mem_we=1 with its address and data in cycle E+1.
- Last beat accepted at edge L:
  - L+1: din_ready=0, last data byte written.
  - L+2: CRC high byte written.
  - L+3: CRC low byte written.
  - L+4: done=1, busy=0, crc_out and frame_len valid.
  - L+5: a new start may be accepted.
- mem_we is low on any cycle without a write, including din_valid gaps.
- Throughput: one payload byte per cycle; frame overhead is 5 cycles.

## Structure
- Package crc_pkg holds:
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF.
  - The FSM state enum type.
  - The function crc16_byte(crc, byte) giving the 8-bit unrolled update. It is shared with the checker.
- One natural sub-module, crc16_update: combinational next-CRC from current CRC and a byte, wrapping the package function. The top level holds the FSM, address counter and output registers.

## Test plan
- Payload "123456789" (0x31..0x39), base 0x000, din_valid continuous:
  - Writes 0x31..0x39 to 0x000..0x008, then 0x29 at 0x009 and 0xB1 at 0x00A.
  - crc_out=0x29B1, frame_len=9, single done pulse at L+4.
- Single byte 0x00 with din_last=1, base 0x100: writes 0x00@0x100, 0xE1@0x101, 0xF0@0x102; crc_out=0xE1F0.
- Base 0x3FC, payload 0x01,0x02,0x03,0x04:
  - Data lands at 0x3FC..0x3FF; CRC bytes at 0x000 and 0x001.
  - CRC equals that of the same frame at base 0.
- "123456789" with din_valid low on alternate cycles: no mem_we during gaps; crc_out=0x29B1 unchanged.
- 1023 bytes with din_last never asserted:
  - Exactly 1022 bytes accepted, din_ready=0 afterwards.
  - err=1, frame_len=1022, CRC written at offsets 1022 and 1023.
- rst asserted after 3 of 9 bytes:
  - Next cycle IDLE, mem_we=0, busy=0, no done.
  - start during a frame is ignored.
  - A following full "123456789" frame yields 0x29B1.
